// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the CDB arbiter: requester indices, default widths,
// the held-result record and a small occupancy helper.
package cdb_arbiter_pkg;

    localparam int REQ_INT  = 0;
    localparam int REQ_LDST = 1;
    localparam int REQ_MUL  = 2;
    localparam int REQ_DIV  = 3;

    localparam int DEF_TAG_WIDTH  = 6;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_REQ    = 4;

    typedef struct packed {
        logic [DEF_TAG_WIDTH-1:0]  tag;
        logic [DEF_DATA_WIDTH-1:0] data;
        logic                      branch;
        logic                      taken;
    } cdb_result_t;

    function automatic logic [2:0] count_held(input logic [DEF_NUM_REQ-1:0] v);
        logic [2:0] cnt;
        cnt = '0;
        for (int i = 0; i < DEF_NUM_REQ; i++) begin
            cnt = cnt + 3'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// The pointer itself is owned and advanced by the parent.
module cdb_arbiter_rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one holding slot per execution requester, a
// round-robin pick each cycle, and registered CDB broadcast outputs.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_branch,
    input  logic [NUM_REQ-1:0]            req_taken,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          CDB_valid,
    output logic [TAG_WIDTH-1:0]          CDB_tag,
    output logic [DATA_WIDTH-1:0]         CDB_data,
    output logic                          CDB_branch,
    output logic                          CDB_branch_taken,
    output logic [NUM_REQ-1:0]            cdb_grant,
    output logic [2:0]                    cdb_pending
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] held;
    logic [NUM_REQ-1:0] win;
    logic [NUM_REQ-1:0] accept;
    logic [NUM_REQ-1:0] held_nxt;
    cdb_result_t        slot_q [NUM_REQ];
    cdb_result_t        sel;
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      win_idx;

    cdb_arbiter_rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
        .req   (held),
        .ptr   (rr_ptr),
        .grant (win)
    );

    // Ready is masked while reset is asserted so nothing is handed off into
    // a slot that is being cleared.
    assign req_ready = reset ? (~held | win) : '0;
    assign accept    = req_valid & req_ready;
    assign held_nxt  = (held & ~win) | accept;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_slot
        logic        held_r;
        cdb_result_t slot_r;

        always_ff @(posedge clk) begin
            if (!reset) begin
                held_r <= 1'b0;
                slot_r <= '0;
            end else begin
                held_r <= held_nxt[k];
                if (accept[k]) begin
                    slot_r <= '{tag:    req_tag[k*TAG_WIDTH +: TAG_WIDTH],
                                data:   req_data[k*DATA_WIDTH +: DATA_WIDTH],
                                branch: req_branch[k],
                                taken:  req_taken[k]};
                end
            end
        end

        assign held[k]   = held_r;
        assign slot_q[k] = slot_r;
    end

    always_comb begin
        sel     = '0;
        win_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win[k]) begin
                sel     = slot_q[k];
                win_idx = PW'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr           <= '0;
            CDB_valid        <= 1'b0;
            CDB_tag          <= '0;
            CDB_data         <= '0;
            CDB_branch       <= 1'b0;
            CDB_branch_taken <= 1'b0;
            cdb_grant        <= '0;
            cdb_pending      <= '0;
        end else begin
            CDB_valid        <= |win;
            cdb_grant        <= win;
            CDB_branch       <= (|win) & sel.branch;
            CDB_branch_taken <= (|win) & sel.branch & sel.taken;
            cdb_pending      <= count_held(held_nxt);
            // Tag/data keep their last value when idle; only valid cycles matter.
            if (|win) begin
                CDB_tag  <= sel.tag;
                CDB_data <= sel.data;
                rr_ptr   <= (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: expected broadcasts queued at hand-off, checked by a
// monitor as they appear on the CDB; table vectors plus corner sequences.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int TW = 6;
    localparam int DW = 32;
    localparam int N  = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_branch, req_taken, req_ready;
    logic [N*TW-1:0] req_tag;
    logic [N*DW-1:0] req_data;
    logic            CDB_valid, CDB_branch, CDB_branch_taken;
    logic [TW-1:0]   CDB_tag;
    logic [DW-1:0]   CDB_data;
    logic [N-1:0]    cdb_grant;
    logic [2:0]      cdb_pending;

    cdb_arbiter #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .NUM_REQ(N)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
        .req_branch(req_branch), .req_taken(req_taken), .req_ready(req_ready),
        .CDB_valid(CDB_valid), .CDB_tag(CDB_tag), .CDB_data(CDB_data),
        .CDB_branch(CDB_branch), .CDB_branch_taken(CDB_branch_taken),
        .cdb_grant(cdb_grant), .cdb_pending(cdb_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
        logic          branch;
        logic          taken;
        logic [N-1:0]  grant;
    } exp_t;

    typedef struct {
        logic [N-1:0]  valid;
        logic [N-1:0]  branch;
        logic [N-1:0]  taken;
        logic [TW-1:0] tag_base;
        int            exp_pending;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vt[6];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] data_of(input logic [TW-1:0] tag);
        return {16'hC0DE, 10'h0, tag};
    endfunction

    task automatic clear_inputs();
        req_valid  = '0;
        req_branch = '0;
        req_taken  = '0;
        req_tag    = '0;
        req_data   = '0;
    endtask

    task automatic drive_slot(input int k, input logic [TW-1:0] tag, input logic [DW-1:0] data,
                              input logic br, input logic tk);
        req_valid[k]           = 1'b1;
        req_tag[k*TW +: TW]    = tag;
        req_data[k*DW +: DW]   = data;
        req_branch[k]          = br;
        req_taken[k]           = tk;
    endtask

    task automatic push_exp(input int k, input logic [TW-1:0] tag, input logic [DW-1:0] data,
                            input logic br, input logic tk);
        exp_t e;
        e.tag    = tag;
        e.data   = data;
        e.branch = br;
        e.taken  = br & tk;
        e.grant  = N'(1 << k);
        sb.push_back(e);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        repeat (cycles) @(negedge clk);
        reset = 1'b1;
    endtask

    // Every broadcast must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (CDB_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_broadcast: got tag %0h grant %b expected none at %0t",
                         CDB_tag, cdb_grant, $time);
            end else begin
                mon_e = sb.pop_front();
                chk("cdb_tag",    32'(CDB_tag),          32'(mon_e.tag));
                chk("cdb_data",   CDB_data,              mon_e.data);
                chk("cdb_branch", 32'(CDB_branch),       32'(mon_e.branch));
                chk("cdb_taken",  32'(CDB_branch_taken), 32'(mon_e.taken));
                chk("cdb_grant",  32'(cdb_grant),        32'(mon_e.grant));
            end
        end else if (reset === 1'b1) begin
            chk("idle_grant",  32'(cdb_grant), 32'h0);
            chk("idle_branch", {30'h0, CDB_branch, CDB_branch_taken}, 32'h0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, low, cyc;
        bit div_sent;

        vt[0] = '{4'b1111, 4'b0000, 4'b0000, 6'd1,  4};
        vt[1] = '{4'b0010, 4'b0010, 4'b0010, 6'd6,  1};
        vt[2] = '{4'b0001, 4'b0000, 4'b0001, 6'd30, 1};
        vt[3] = '{4'b1010, 4'b1000, 4'b0000, 6'd32, 2};
        vt[4] = '{4'b0101, 4'b0101, 4'b0100, 6'd36, 2};
        vt[5] = '{4'b1110, 4'b0110, 4'b1110, 6'd44, 3};

        reset = 1'b0;
        clear_inputs();

        // Reset with everyone requesting: no ready, nothing on the bus.
        @(negedge clk);
        req_valid = 4'hF;
        #1 chk("ready_in_reset", 32'(req_ready), 32'h0);
        @(negedge clk);
        chk("ready_in_reset2", 32'(req_ready), 32'h0);
        chk("valid_in_reset", 32'(CDB_valid), 32'h0);
        req_valid = '0;
        reset = 1'b1;
        @(negedge clk);
        chk("pending_after_reset", 32'(cdb_pending), 32'h0);
        chk("valid_after_reset", 32'(CDB_valid), 32'h0);
        chk("ready_after_reset", 32'(req_ready), 32'hF);

        // Single int result: one-cycle latency, one-cycle visibility.
        drive_slot(REQ_INT, 6'd5, 32'hDEAD_BEEF, 1'b0, 1'b0);
        push_exp(REQ_INT, 6'd5, 32'hDEAD_BEEF, 1'b0, 1'b0);
        @(negedge clk);
        clear_inputs();
        chk("single_pending", 32'(cdb_pending), 32'h1);
        chk("single_not_yet", 32'(CDB_valid), 32'h0);
        @(negedge clk);
        chk("single_valid", 32'(CDB_valid), 32'h1);
        chk("single_pending_drained", 32'(cdb_pending), 32'h0);
        @(negedge clk);
        chk("single_one_cycle", 32'(CDB_valid), 32'h0);

        // Pointer now past int: div must win over int.
        drive_slot(REQ_INT, 6'd20, data_of(6'd20), 1'b0, 1'b0);
        drive_slot(REQ_DIV, 6'd23, data_of(6'd23), 1'b0, 1'b0);
        push_exp(REQ_DIV, 6'd23, data_of(6'd23), 1'b0, 1'b0);
        push_exp(REQ_INT, 6'd20, data_of(6'd20), 1'b0, 1'b0);
        @(negedge clk);
        clear_inputs();
        repeat (3) @(negedge clk);

        // Table vectors from reset (pointer 0): ascending service, pending drains.
        for (int i = 0; i < 6; i++) begin
            do_reset(1);
            for (int k = 0; k < N; k++) begin
                if (vt[i].valid[k]) begin
                    drive_slot(k, vt[i].tag_base + TW'(k), data_of(vt[i].tag_base + TW'(k)),
                               vt[i].branch[k], vt[i].taken[k]);
                    push_exp(k, vt[i].tag_base + TW'(k), data_of(vt[i].tag_base + TW'(k)),
                             vt[i].branch[k], vt[i].taken[k]);
                end
            end
            @(negedge clk);
            clear_inputs();
            chk("vec_pending", 32'(cdb_pending), 32'(vt[i].exp_pending));
            for (int j = 1; j <= vt[i].exp_pending; j++) begin
                @(negedge clk);
                chk("vec_pending_drain", 32'(cdb_pending), 32'(vt[i].exp_pending - j));
            end
            @(negedge clk);
        end

        // Mul streams tags 10..19; div cuts in once mid-stream.
        do_reset(1);
        t = 0;
        low = 0;
        div_sent = 1'b0;
        for (cyc = 0; cyc < 40 && t < 10; cyc++) begin
            drive_slot(REQ_MUL, 6'(10 + t), data_of(6'(10 + t)), 1'b0, 1'b0);
            if (t == 5 && !div_sent)
                drive_slot(REQ_DIV, 6'd40, data_of(6'd40), 1'b0, 1'b0);
            #1;
            if (req_valid[REQ_DIV] && req_ready[REQ_DIV]) begin
                push_exp(REQ_DIV, 6'd40, data_of(6'd40), 1'b0, 1'b0);
                div_sent = 1'b1;
            end
            if (req_ready[REQ_MUL]) begin
                push_exp(REQ_MUL, 6'(10 + t), data_of(6'(10 + t)), 1'b0, 1'b0);
                t++;
            end else begin
                low++;
            end
            @(negedge clk);
            req_valid[REQ_DIV] = 1'b0;
        end
        clear_inputs();
        chk("stream_done", 32'(t), 32'd10);
        chk("stream_cycles", 32'(cyc), 32'd11);
        chk("stream_ready_drops", 32'(low), 32'd1);
        chk("div_served", 32'(div_sent), 32'd1);
        repeat (4) @(negedge clk);

        // Reset while three slots are held: all of them are discarded.
        do_reset(1);
        drive_slot(REQ_INT,  6'd50, data_of(6'd50), 1'b0, 1'b0);
        drive_slot(REQ_LDST, 6'd51, data_of(6'd51), 1'b1, 1'b1);
        drive_slot(REQ_MUL,  6'd52, data_of(6'd52), 1'b0, 1'b0);
        @(negedge clk);
        clear_inputs();
        chk("held3_pending", 32'(cdb_pending), 32'h3);
        reset = 1'b0;
        #1 chk("held3_ready_in_reset", 32'(req_ready), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        chk("held3_pending_cleared", 32'(cdb_pending), 32'h0);
        chk("held3_valid_cleared", 32'(CDB_valid), 32'h0);
        repeat (6) @(negedge clk);

        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
